// File: rtl/break_value_counter.sv
// -----------------------------------------------------------------------------
// break_value_counter
//
// Purpose:
//   Registered population counter for the WalkSAT flip-selection datapath.
//   Counts the per-clause break flags of one candidate variable and presents
//   the count (the variable's break value) one clock later. The flag vector is
//   split into NUM_ROWS contiguous groups of ceil(NUM_CLAUSES/NUM_ROWS) bits.
//   Each group is popcounted separately, and the partial sums are then added.
//   The grouping only shapes the adder tree. The result is always the plain
//   popcount of the vector.
//
// Ports:
//   clk         - single clock; all state updates on the rising edge
//   reset       - synchronous, active-low reset; clears break_value to 0
//   clause      - [NUM_CLAUSES-1:0] per-clause break flags (bit i = clause i breaks)
//   break_value - [NUM_CLAUSES_BITS-1:0] registered count of set bits in clause
//
// Configuration macro:
//   BREAK_VALUE_SATURATE_EN - when defined, totals above 2^NUM_CLAUSES_BITS-1
//   clamp to all-ones, and the NUM_CLAUSES_BITS width check is relaxed. When
//   undefined, the total is truncated, and the width check is enforced at
//   elaboration.
// -----------------------------------------------------------------------------
module break_value_counter #(
   parameter int NUM_CLAUSES      = 20,
   parameter int NUM_ROWS         = 3,
   parameter int NUM_CLAUSES_BITS = 5
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CLAUSES-1:0]      clause,
   output logic [NUM_CLAUSES_BITS-1:0] break_value
);

   // Bits per group (ceiling division). The last group holds the remainder.
   localparam int GROUP_W = (NUM_CLAUSES + NUM_ROWS - 1) / NUM_ROWS;
   // Padded width so that every group can be sliced uniformly.
   localparam int PAD_W   = GROUP_W * NUM_ROWS;
   // Width needed to hold the full count without overflow.
   localparam int CNT_W   = $clog2(NUM_CLAUSES + 1);
   // The internal sum is one bit wider than both the count and the output.
   // This guarantees a non-empty overflow slice above the output bits.
   localparam int SUM_W   = ((CNT_W > NUM_CLAUSES_BITS) ? CNT_W : NUM_CLAUSES_BITS) + 1;

   // Elaboration-time parameter legality.
   if ((NUM_ROWS < 1) || (NUM_ROWS > NUM_CLAUSES)) begin : g_bad_rows
      $fatal(1, "break_value_counter: NUM_ROWS must be in 1..NUM_CLAUSES");
   end
`ifndef BREAK_VALUE_SATURATE_EN
   if ((64'd1 << NUM_CLAUSES_BITS) <= 64'(NUM_CLAUSES)) begin : g_bad_bits
      $fatal(1, "break_value_counter: 2**NUM_CLAUSES_BITS must exceed NUM_CLAUSES");
   end
`endif

   logic [PAD_W-1:0]            padded_s;
   logic [SUM_W-1:0]            part_s [NUM_ROWS];
   logic [SUM_W-1:0]            total_s;
   logic [NUM_CLAUSES_BITS-1:0] break_value_d;
   logic [NUM_CLAUSES_BITS-1:0] break_value_q;

   // Zero-extend the flag vector so the tail of the last group counts as empty.
   always_comb begin
      padded_s                  = {PAD_W{1'b0}};
      padded_s[NUM_CLAUSES-1:0] = clause;
   end

   // Per-group popcount, then the sum of the partial sums.
   always_comb begin
      total_s = {SUM_W{1'b0}};
      for (int r = 0; r < NUM_ROWS; r++) begin
         part_s[r] = {SUM_W{1'b0}};
         for (int b = 0; b < GROUP_W; b++) begin
            part_s[r] = part_s[r] + {{(SUM_W-1){1'b0}}, padded_s[r*GROUP_W + b]};
         end
         total_s = total_s + part_s[r];
      end
   end

   // Narrow the total to the output width.
   always_comb begin
`ifdef BREAK_VALUE_SATURATE_EN
      // Any bit above the output width means the total cannot be represented.
      if (|total_s[SUM_W-1:NUM_CLAUSES_BITS]) begin
         break_value_d = {NUM_CLAUSES_BITS{1'b1}};
      end else begin
         break_value_d = total_s[NUM_CLAUSES_BITS-1:0];
      end
`else
      break_value_d = total_s[NUM_CLAUSES_BITS-1:0];
`endif
   end

   // Output register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         break_value_q <= {NUM_CLAUSES_BITS{1'b0}};
      end else begin
         break_value_q <= break_value_d;
      end
   end

   assign break_value = break_value_q;

endmodule

// File: tb/tb_break_value_counter.sv
module tb_break_value_counter;

   localparam int NC = 20;
   localparam int NR = 3;
`ifdef BREAK_VALUE_SATURATE_EN
   localparam int NB = 4;
`else
   localparam int NB = 5;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [NC-1:0] clause = 20'hFFFFF;
   logic [NB-1:0] break_value;

   int checks = 0;
   int failures = 0;

   break_value_counter #(
      .NUM_CLAUSES(NC), .NUM_ROWS(NR), .NUM_CLAUSES_BITS(NB)
   ) dut (
      .clk(clk), .reset(reset), .clause(clause), .break_value(break_value)
   );

   always #5 clk = ~clk;

   // Narrow a raw popcount to the output width, following the build's overflow policy.
   function automatic int narrow(input int c);
      int mx;
      mx = (1 << NB) - 1;
`ifdef BREAK_VALUE_SATURATE_EN
      return (c > mx) ? mx : c;
`else
      return c % (1 << NB);
`endif
   endfunction

   // Reference model: the count of set flags, or 0 when reset is low at the edge.
   function automatic int ref_model(input logic rst_n, input logic [NC-1:0] v);
      int c;
      c = 0;
      if (rst_n !== 1'b1) return 0;
      for (int i = 0; i < NC; i++) c += (v[i] ? 1 : 0);
      return narrow(c);
   endfunction

   task automatic check(input string name, input int exp);
      checks++;
      if (break_value !== NB'(exp)) begin
         failures++;
         $display("FAIL %s: break_value=%0d expected=%0d", name, break_value, exp);
      end
   endtask

   typedef struct {
      logic          rst_n;
      logic [NC-1:0] vec;
      int            count;   // raw popcount expected after one edge (0 under reset)
   } vec_t;

   vec_t tbl[16];
   int   exp_q[$];

   initial begin
      tbl[0]  = '{1'b0, 20'hFFFFF, 0};
      tbl[1]  = '{1'b0, 20'hFFFFF, 0};
      tbl[2]  = '{1'b1, 20'h00000, 0};
      tbl[3]  = '{1'b1, 20'h00001, 1};
      tbl[4]  = '{1'b1, 20'h80000, 1};
      tbl[5]  = '{1'b1, 20'hFFFFF, 20};
      tbl[6]  = '{1'b1, 20'hAAAAA, 10};
      tbl[7]  = '{1'b1, 20'h0007F, 7};
      tbl[8]  = '{1'b1, 20'h00080, 1};
      tbl[9]  = '{1'b1, 20'h02000, 1};
      tbl[10] = '{1'b1, 20'h04000, 1};
      tbl[11] = '{1'b1, 20'h03F80, 7};
      tbl[12] = '{1'b1, 20'hFC000, 6};
      tbl[13] = '{1'b1, 20'h55555, 10};
      tbl[14] = '{1'b0, 20'hFFFFF, 0};
      tbl[15] = '{1'b1, 20'hFFFFF, 20};

      // Directed table: drive at one negedge, check at the next.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         reset  = tbl[i].rst_n;
         clause = tbl[i].vec;
         @(negedge clk);
         check($sformatf("tbl[%0d]", i), narrow(tbl[i].count));
      end

      // Mid-stream reset pulse with all flags held set.
      @(negedge clk); reset = 1'b1; clause = 20'hFFFFF;
      @(negedge clk); check("pre_pulse", narrow(20));
      reset = 1'b0;
      @(negedge clk); check("pulse_low", 0);
      reset = 1'b1;
      @(negedge clk); check("pulse_release", narrow(20));

      // The output must not follow the input before the next edge.
      clause = 20'h00000;
      #1 check("no_comb_path", narrow(20));
      @(negedge clk); check("after_edge", 0);

      // Back-to-back random vectors, with occasional reset, one per cycle.
      exp_q.delete();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (exp_q.size() > 0) check($sformatf("rand[%0d]", k - 1), exp_q.pop_front());
         reset  = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
         clause = NC'($urandom);
         if (k % 7 == 0) clause = {NC{1'b1}};
         exp_q.push_back(ref_model(reset, clause));
      end
      @(negedge clk);
      check("rand_last", exp_q.pop_front());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/break_value_counter.md
# break_value_counter

Registered population counter for the WalkSAT flip-selection datapath. It takes one vector of per-clause break flags for a candidate variable. Each set bit marks a clause that would become unsatisfied if that variable were flipped. It outputs the number of set flags (the variable's break value) one clock later. The downstream variable-selection logic compares these counts to pick the flip candidate.

## Interface
- `NUM_CLAUSES`, default 20: width of the clause flag vector.
- `NUM_ROWS`, default 3: number of partial-sum groups in the adder structure. Legal range is 1..`NUM_CLAUSES`.
- `NUM_CLAUSES_BITS`, default 5: width of the break value output. Must satisfy 2^`NUM_CLAUSES_BITS` > `NUM_CLAUSES`.
- `clk`, input, 1 bit: single clock. All state updates on the rising edge.
- `reset`, input, 1 bit: synchronous, active-low reset.
- `clause`, input, `NUM_CLAUSES` bits: per-clause break flags. Bit i = 1 means clause i breaks.
- `break_value`, output, `NUM_CLAUSES_BITS` bits: registered count of set bits in `clause`.

## Operation
- Split `clause` into `NUM_ROWS` contiguous groups of ceil(`NUM_CLAUSES`/`NUM_ROWS`) bits, starting at bit 0. The last group holds the remainder. For the defaults the groups are bits [6:0], [13:7] and [19:14].
- Each group is popcounted combinationally into a partial sum. The partial sums are added combinationally into the total.
- Grouping affects structure only. The result equals the plain popcount of `clause` for every `NUM_ROWS`.
- The total is registered into `break_value` on each rising edge of `clk` when `reset` is high.
- Arithmetic width:
  - Internal sums are wide enough that they never overflow.
  - The final value is truncated to `NUM_CLAUSES_BITS` bits.
  - With legal parameters truncation never loses information. See Configuration for the overflow policy.
- The block has no handshake and no enable. A new vector is accepted every cycle, with full throughput.
- Any X/Z on `clause` may propagate to `break_value`. No sanitising is performed.
- Parameter legality is checked at elaboration. A violation of 2^`NUM_CLAUSES_BITS` > `NUM_CLAUSES`, or `NUM_ROWS` outside 1..`NUM_CLAUSES`, is a fatal error.

## Timing
- Latency is 1 cycle. If `clause` is stable before rising edge N, its popcount appears on `break_value` after edge N. It is valid for the whole following cycle.
- There is no combinational path from `clause` to `break_value`.
- Reset behaviour:
  - When `reset` = 0 at a rising edge, `break_value` becomes 0 regardless of `clause`.
  - The reset value of `break_value` is 0.
- Reset mid-stream: the cycle after reset is asserted shows 0. The first edge with `reset` = 1 loads the popcount of the vector present at that edge.
- Back-to-back changes: every cycle's output reflects exactly the vector sampled at the preceding edge. Nothing is held or averaged.

## Configuration
- `BREAK_VALUE_SATURATE_EN`, when defined:
  - The elaboration check on `NUM_CLAUSES_BITS` is relaxed.
  - A total that exceeds 2^`NUM_CLAUSES_BITS`−1 is clamped to all-ones.
- When not defined:
  - The elaboration check is enforced.
  - The total is truncated modulo 2^`NUM_CLAUSES_BITS`, which cannot overflow for legal parameters.
- The latency and reset behaviour are identical in both builds.

## Test plan
All scenarios use the defaults (20/3/5). Apply stimulus at the negative edge and check at the next negative edge.
- Hold `reset` = 0 for 2 cycles with `clause` = 20'hFFFFF → `break_value` = 0 throughout.
- `clause` = 20'h00000 → 0. Then 20'h00001 → 1. Then 20'h80000 → 1. This checks the edge bits of the first and last groups.
- `clause` = 20'hFFFFF → 20. Then 20'hAAAAA → 10. Then 20'h0007F (the first group full) → 7.
- Ten back-to-back random vectors, one per cycle → each output equals the popcount of the vector from the prior cycle, with no gaps.
- `clause` = 20'hFFFFF with `reset` pulsed low for one cycle mid-stream → output 0 for that cycle, then 20 the next cycle.
- Saturation build with `NUM_CLAUSES_BITS` = 4 and `clause` = 20'hFFFFF → 15. In the non-saturating build this parameter set fails elaboration.
